// File: rtl/tr_step_gen.sv
// Tracking stepper: |x-x0| -> period law -> hysteresis FSM -> paced drv_step train with dir setup.
// Latency: dx_r at t+1, N/state at t+2 after data_valid; step rises one cycle after period wrap.
module tr_step_gen #(
    parameter int WIDTH_IN   = 12,
    parameter int WIDTH_WORK = 16,
    parameter int DEADZONE   = 50,
    parameter int HOLD_THR   = 0,
    parameter int L_SHIFT    = 4,
    parameter int PULSE_W    = 8,
    parameter int DIR_SETUP  = 16,
    parameter int POS_W      = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    data_valid,
    input  logic                    tr_mode_enable,
    input  logic [WIDTH_IN-1:0]     x0,
    input  logic [WIDTH_WORK-1:0]   x,
    input  logic [WIDTH_WORK-1:0]   dx1,
    input  logic [WIDTH_WORK-1:0]   dx2,
    input  logic [WIDTH_WORK-1:0]   F1,
    input  logic [WIDTH_WORK-1:0]   F2,
    input  logic [WIDTH_WORK+3:0]   k,
    output logic [WIDTH_WORK-1:0]   N,
    output logic                    drv_step,
    output logic                    drv_dir,
    output logic                    drv_enable_SM,
    output logic [POS_W-1:0]        step_pos
);

    localparam int PRW = 2 * WIDTH_WORK + 4;
    localparam int TW  = (DIR_SETUP > 0) ? $clog2(DIR_SETUP + 1) : 1;
    localparam int PCW = $clog2(PULSE_W + 1);

    localparam logic [WIDTH_WORK-1:0] ONE_W   = 1;
    localparam logic [WIDTH_WORK-1:0] PW2     = WIDTH_WORK'(2 * PULSE_W);
    localparam logic [WIDTH_WORK-1:0] DZ_W    = WIDTH_WORK'(DEADZONE);
    localparam logic [WIDTH_WORK-1:0] HOLD_W  = WIDTH_WORK'(HOLD_THR);
    localparam logic [POS_W-1:0]      ONE_P   = 1;
    localparam logic [PCW-1:0]        ONE_C   = 1;
    localparam logic [PCW-1:0]        PW_LAST = PCW'(PULSE_W - 1);
    localparam logic [TW-1:0]         ONE_T   = 1;
    localparam logic [TW-1:0]         DS_LOAD = TW'(DIR_SETUP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                 state;
    logic [WIDTH_WORK-1:0]  x0_ext;
    logic [WIDTH_WORK-1:0]  dx_r;
    logic                   dir_r;
    logic                   s1_vld;
    logic [WIDTH_WORK-1:0]  dx_off;
    logic [PRW-1:0]         prod;
    logic [PRW:0]           sum;
    logic [WIDTH_WORK-1:0]  n_law;
    logic [WIDTH_WORK-1:0]  n_eff;
    logic [WIDTH_WORK-1:0]  cnt;
    logic [WIDTH_WORK-1:0]  p_act;
    logic [PCW-1:0]         pw_cnt;
    logic [TW-1:0]          dir_tmr;
    logic                   req_pend;
    logic                   in_track;
    logic                   wrap;
    logic                   go;

    assign x0_ext = {{(WIDTH_WORK-WIDTH_IN){1'b0}}, x0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx_r   <= '0;
            dir_r  <= 1'b0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= data_valid;
            if (data_valid) begin
                dx_r  <= (x <= x0_ext) ? (x0_ext - x) : (x - x0_ext);
                dir_r <= (x <= x0_ext);
            end
        end
    end

    // Full-width slope product; only the final sum is saturated.
    assign dx_off = dx_r - dx1;
    assign prod   = k * dx_off;
    assign sum    = {{(PRW-WIDTH_WORK+1){1'b0}}, F1} + {1'b0, prod >> L_SHIFT};

    always_comb begin
        n_law = F1;
        if (dx_r >= dx2) begin
            n_law = F2;
        end else if (dx_r >= dx1) begin
            n_law = (|sum[PRW:WIDTH_WORK]) ? '1 : sum[WIDTH_WORK-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            N <= '0;
        end else if (s1_vld) begin
            N <= n_law;
        end
    end

    assign n_eff = (N == '0) ? '0 : ((N < PW2) ? PW2 : N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            drv_enable_SM <= 1'b0;
        end else if (!tr_mode_enable) begin
            state         <= S_IDLE;
            drv_enable_SM <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state         <= S_TRACK;
                    drv_enable_SM <= 1'b1;
                end
                S_TRACK: begin
                    if (dx_r <= HOLD_W) begin
                        state         <= S_HOLD;
                        drv_enable_SM <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (dx_r >= DZ_W) begin
                        state         <= S_TRACK;
                        drv_enable_SM <= 1'b1;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    drv_enable_SM <= 1'b0;
                end
            endcase
        end
    end

    assign in_track = (state == S_TRACK);
    assign wrap     = in_track && (p_act != '0) && (cnt == p_act - ONE_W);
    assign go       = (wrap || req_pend) && in_track && !drv_step && (dir_tmr == '0);

    // The active period is latched only at wrap so a new N never cuts a period short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            p_act <= '0;
        end else if (!in_track) begin
            cnt   <= '0;
            p_act <= n_eff;
        end else if (p_act == '0) begin
            cnt   <= '0;
            p_act <= n_eff;
        end else if (wrap) begin
            cnt   <= '0;
            p_act <= n_eff;
        end else begin
            cnt   <= cnt + ONE_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pend <= 1'b0;
        end else if (!in_track || go) begin
            req_pend <= 1'b0;
        end else if (wrap) begin
            req_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_step <= 1'b0;
            pw_cnt   <= '0;
            step_pos <= '0;
        end else if (go) begin
            drv_step <= 1'b1;
            pw_cnt   <= PW_LAST;
            step_pos <= drv_dir ? (step_pos + ONE_P) : (step_pos - ONE_P);
        end else if (drv_step) begin
            if (pw_cnt == '0) begin
                drv_step <= 1'b0;
            end else begin
                pw_cnt <= pw_cnt - ONE_C;
            end
        end
    end

    // Direction may not move during a pulse or on the edge that starts one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_dir <= 1'b0;
            dir_tmr <= '0;
        end else if (!drv_step && !go && (drv_dir != dir_r)) begin
            drv_dir <= dir_r;
            dir_tmr <= DS_LOAD;
        end else if (dir_tmr != '0) begin
            dir_tmr <= dir_tmr - ONE_T;
        end
    end

endmodule
